// File: rtl/fht_pkg.sv
// Shared types and constants for the FHT frame sequencer: controller states,
// bank-port ownership codes and the frame length helper.
package fht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN_WAIT,
        ST_RUN,
        ST_UNLOAD,
        ST_DRAIN
    } fht_frame_st_t;

    localparam logic [1:0] MUX_NONE   = 2'd0;
    localparam logic [1:0] MUX_LOAD   = 2'd1;
    localparam logic [1:0] MUX_CORE   = 2'd2;
    localparam logic [1:0] MUX_UNLOAD = 2'd3;

    // Samples per frame: four banks of 2^a_bit words each.
    function automatic int unsigned frame_len(input int unsigned a_bit);
        return 32'd4 << a_bit;
    endfunction

endpackage

// File: rtl/fht_frame_cnt.sv
// Sample index counter shared by the loader and unloader; splits the index
// into bank (low two bits) and in-bank address, and flags the last sample.
module fht_frame_cnt
    import fht_pkg::*;
#(
    parameter int A_BIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [1:0]       bank_o,
    output logic [A_BIT-1:0] addr_o,
    output logic             last_o
);

    localparam int                CNT_W    = A_BIT + 2;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(frame_len(A_BIT) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holds at the last index; only an explicit clear returns it to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bank_o = cnt_q[1:0];
    assign addr_o = cnt_q[CNT_W-1:2];
    assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/fht_frame_ctrl.sv
// Frame sequencer around fht_control: loads one frame into the four banks,
// kicks the core, waits for completion and streams the results out.
module fht_frame_ctrl
    import fht_pkg::*;
#(
    parameter int A_BIT = 8
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iEN,
    input  logic             iVALID,
    output logic             oREADY,
    output logic             oIN_WE,
    output logic [1:0]       oIN_BANK,
    output logic [A_BIT-1:0] oIN_ADDR,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    input  logic             iFHT_RES_SEL,
    output logic [1:0]       oMUX_SEL,
    output logic             oOUT_RD,
    output logic             oOUT_SET,
    output logic [1:0]       oOUT_BANK,
    output logic [A_BIT-1:0] oOUT_ADDR,
    output logic             oVALID,
    input  logic             iOUT_READY,
    output logic             oBUSY,
    output logic             oFRAME_DONE
);

    fht_frame_st_t state_q, state_d;

    logic start_q, start_d;
    logic valid_q, valid_d;
    logic set_q,   set_d;

    logic             cnt_clear;
    logic             cnt_inc;
    logic [1:0]       cnt_bank;
    logic [A_BIT-1:0] cnt_addr;
    logic             cnt_last;

    fht_frame_cnt #(
        .A_BIT (A_BIT)
    ) u_cnt (
        .clk_i   (iCLK),
        .rst_ni  (iRESET),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .bank_o  (cnt_bank),
        .addr_o  (cnt_addr),
        .last_o  (cnt_last)
    );

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter is cleared on every transition into LOAD or UNLOAD, so each
    // phase walks the frame from sample 0 in natural order.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        start_d   = 1'b0;
        set_d     = set_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iEN) begin
                    state_d   = ST_LOAD;
                    cnt_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                if (oIN_WE) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                if (iFHT_RDY) begin
                    start_d = 1'b1;
                    state_d = ST_RUN_WAIT;
                end
            end
            ST_RUN_WAIT: begin
                if (!iFHT_RDY) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iFHT_RDY) begin
                    set_d     = iFHT_RES_SEL;
                    cnt_clear = 1'b1;
                    state_d   = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (oOUT_RD) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (oFRAME_DONE) begin
                    if (iEN) begin
                        state_d   = ST_LOAD;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        oREADY      = 1'b0;
        oMUX_SEL    = MUX_NONE;
        oOUT_RD     = 1'b0;
        oFRAME_DONE = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                oREADY   = 1'b1;
                oMUX_SEL = MUX_LOAD;
            end
            ST_START, ST_RUN_WAIT, ST_RUN: begin
                oMUX_SEL = MUX_CORE;
            end
            ST_UNLOAD: begin
                oMUX_SEL = MUX_UNLOAD;
                oOUT_RD  = !valid_q || iOUT_READY;
            end
            ST_DRAIN: begin
                oMUX_SEL    = MUX_UNLOAD;
                oFRAME_DONE = valid_q && iOUT_READY;
            end
            default: begin
                oMUX_SEL = MUX_NONE;
            end
        endcase
    end

    // Read data lands one cycle after the strobe and stays presented until
    // downstream takes it; no new read is issued while it is stalled.
    always_comb begin
        valid_d = valid_q;
        if (oOUT_RD) begin
            valid_d = 1'b1;
        end else if (iOUT_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            valid_q <= valid_d;
            set_q   <= set_d;
        end
    end

    assign oIN_WE     = iVALID & oREADY;
    assign oIN_BANK   = cnt_bank;
    assign oIN_ADDR   = cnt_addr;
    assign oOUT_BANK  = cnt_bank;
    assign oOUT_ADDR  = cnt_addr;
    assign oFHT_START = start_q;
    assign oVALID     = valid_q;
    assign oOUT_SET   = set_q;
    assign oBUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// Bench for fht_frame_ctrl with a frame-level reference model, a simple
// stand-in for fht_control, directed frames and randomized frames.
module tb_fht_frame_ctrl;

    localparam int A_BIT = 2;
    localparam int N     = 16;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iEN;
    logic             iVALID;
    logic             oREADY;
    logic             oIN_WE;
    logic [1:0]       oIN_BANK;
    logic [A_BIT-1:0] oIN_ADDR;
    logic             oFHT_START;
    logic             iFHT_RDY;
    logic             iFHT_RES_SEL;
    logic [1:0]       oMUX_SEL;
    logic             oOUT_RD;
    logic             oOUT_SET;
    logic [1:0]       oOUT_BANK;
    logic [A_BIT-1:0] oOUT_ADDR;
    logic             oVALID;
    logic             iOUT_READY;
    logic             oBUSY;
    logic             oFRAME_DONE;

    int total = 0;
    int bad   = 0;

    bit coreBusy   = 1'b0;
    int coreDelay  = 0;
    int coreLow    = 0;
    int cfgDelay   = 0;
    int cfgLow     = 1;
    bit cfgSel     = 1'b0;
    bit cfgIdleRdy = 1'b1;

    fht_frame_ctrl #(
        .A_BIT (A_BIT)
    ) dut (
        .iCLK         (iCLK),
        .iRESET       (iRESET),
        .iEN          (iEN),
        .iVALID       (iVALID),
        .oREADY       (oREADY),
        .oIN_WE       (oIN_WE),
        .oIN_BANK     (oIN_BANK),
        .oIN_ADDR     (oIN_ADDR),
        .oFHT_START   (oFHT_START),
        .iFHT_RDY     (iFHT_RDY),
        .iFHT_RES_SEL (iFHT_RES_SEL),
        .oMUX_SEL     (oMUX_SEL),
        .oOUT_RD      (oOUT_RD),
        .oOUT_SET     (oOUT_SET),
        .oOUT_BANK    (oOUT_BANK),
        .oOUT_ADDR    (oOUT_ADDR),
        .oVALID       (oVALID),
        .iOUT_READY   (iOUT_READY),
        .oBUSY        (oBUSY),
        .oFRAME_DONE  (oFRAME_DONE)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; also plays fht_control: after a start pulse it
    // keeps RDY high for cfgDelay cycles, low for cfgLow cycles, then finishes.
    task automatic applyStimulus(input bit v, input bit ordy, input bit en, input bit rstn);
        bit sawStart;
        sawStart = oFHT_START;
        @(posedge iCLK);
        #1;
        iVALID     = v;
        iOUT_READY = ordy;
        iEN        = en;
        iRESET     = rstn;
        if (sawStart) begin
            coreBusy  = 1'b1;
            coreDelay = cfgDelay;
            coreLow   = cfgLow;
        end
        if (coreBusy) begin
            if (coreDelay > 0) begin
                coreDelay--;
                iFHT_RDY = 1'b1;
            end else if (coreLow > 0) begin
                coreLow--;
                iFHT_RDY = 1'b0;
            end else begin
                iFHT_RDY     = 1'b1;
                iFHT_RES_SEL = cfgSel;
                coreBusy     = 1'b0;
            end
        end else begin
            iFHT_RDY = cfgIdleRdy;
        end
    endtask

    // Modes: vMode 0 = always valid, else random; rdyMode 0 = always ready,
    // 1 = 1,0,0,1 pattern, 2 = random; enMode 0 = 1, 1 = 0, 2 = random with resets.
    task automatic runUntilDone(input int maxCycles, input int vMode, input int rdyMode,
                                input int enMode, output int starts, output int accepts,
                                output int latency, output bit gotDone);
        int riseAt;
        int validAt;
        bit prevRdy;
        bit v, o, e, r;
        riseAt  = -1;
        validAt = -1;
        starts  = 0;
        accepts = 0;
        latency = -1;
        gotDone = 1'b0;
        prevRdy = iFHT_RDY;
        for (int i = 0; i < maxCycles && !gotDone; i++) begin
            v = (vMode == 0) ? 1'b1 : ($urandom % 3 != 0);
            o = (rdyMode == 0) ? 1'b1 :
                (rdyMode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : ($urandom % 3 != 0);
            e = (enMode == 0) ? 1'b1 : (enMode == 1) ? 1'b0 : ($urandom % 8 != 0);
            r = (enMode == 2) ? ($urandom % 300 != 0) : 1'b1;
            if (vMode != 0) cfgIdleRdy = ($urandom % 4 != 0);
            applyStimulus(v, o, e, r);
            @(negedge iCLK);
            if (oFHT_START) starts++;
            if (oVALID && iOUT_READY) accepts++;
            if (iFHT_RDY && !prevRdy && riseAt < 0) riseAt = i;
            if (oVALID && validAt < 0 && riseAt >= 0) validAt = i;
            prevRdy = iFHT_RDY;
            if (oFRAME_DONE) gotDone = 1'b1;
        end
        if (riseAt >= 0 && validAt >= 0) latency = validAt - riseAt;
    endtask

    // Reference model: the frame as a sequence of phases with a sample index
    // for loading and reading; expected outputs are derived from those.
    typedef enum int {PH_IDLE, PH_LOAD, PH_START, PH_AWAIT_LOW, PH_AWAIT_HIGH,
                      PH_UNLOAD, PH_DRAIN} phase_t;

    initial begin : model
        phase_t mPhase;
        int     mN, mR;
        bit     mValid, mSet, mStart, nextStart;
        int     expMux;
        bit     expReady, expRd, expDone;
        mPhase = PH_IDLE;
        mN = 0; mR = 0; mValid = 0; mSet = 0; mStart = 0;
        forever begin
            @(negedge iCLK);
            if (!iRESET) begin
                mPhase = PH_IDLE;
                mN = 0; mR = 0; mValid = 0; mSet = 0; mStart = 0;
            end
            expReady = (mPhase == PH_LOAD);
            expRd    = (mPhase == PH_UNLOAD) && (!mValid || iOUT_READY);
            expDone  = (mPhase == PH_DRAIN) && mValid && iOUT_READY;
            case (mPhase)
                PH_IDLE:                              expMux = 0;
                PH_LOAD:                              expMux = 1;
                PH_START, PH_AWAIT_LOW, PH_AWAIT_HIGH: expMux = 2;
                default:                              expMux = 3;
            endcase
            checkOutput("m_ready", oREADY, expReady);
            checkOutput("m_we", oIN_WE, expReady && iVALID);
            checkOutput("m_mux", oMUX_SEL, expMux);
            checkOutput("m_start", oFHT_START, mStart);
            checkOutput("m_rd", oOUT_RD, expRd);
            checkOutput("m_set", oOUT_SET, mSet);
            checkOutput("m_valid", oVALID, mValid);
            checkOutput("m_busy", oBUSY, mPhase != PH_IDLE);
            checkOutput("m_done", oFRAME_DONE, expDone);
            if (expReady || !iRESET) begin
                checkOutput("m_in_bank", oIN_BANK, mN % 4);
                checkOutput("m_in_addr", oIN_ADDR, mN / 4);
            end
            if (expRd) begin
                checkOutput("m_out_bank", oOUT_BANK, mR % 4);
                checkOutput("m_out_addr", oOUT_ADDR, mR / 4);
            end
            if (iRESET) begin
                nextStart = 1'b0;
                case (mPhase)
                    PH_IDLE: if (iEN) begin mPhase = PH_LOAD; mN = 0; end
                    PH_LOAD: if (iVALID) begin
                        if (mN == N - 1) mPhase = PH_START; else mN++;
                    end
                    PH_START: if (iFHT_RDY) begin nextStart = 1'b1; mPhase = PH_AWAIT_LOW; end
                    PH_AWAIT_LOW: if (!iFHT_RDY) mPhase = PH_AWAIT_HIGH;
                    PH_AWAIT_HIGH: if (iFHT_RDY) begin
                        mSet = iFHT_RES_SEL; mR = 0; mPhase = PH_UNLOAD;
                    end
                    PH_UNLOAD: begin
                        if (expRd) begin
                            mValid = 1'b1;
                            if (mR == N - 1) mPhase = PH_DRAIN; else mR++;
                        end else if (iOUT_READY) begin
                            mValid = 1'b0;
                        end
                    end
                    PH_DRAIN: if (expDone) begin
                        mValid = 1'b0;
                        mN     = 0;
                        mPhase = iEN ? PH_LOAD : PH_IDLE;
                    end
                    default: mPhase = PH_IDLE;
                endcase
                mStart = nextStart;
            end
        end
    end

    initial begin : main
        int starts, accepts, latency;
        bit gotDone;
        iRESET = 1'b0; iEN = 1'b0; iVALID = 1'b0; iFHT_RDY = 1'b1;
        iFHT_RES_SEL = 1'b0; iOUT_READY = 1'b0;
        repeat (2) @(negedge iCLK);
        checkOutput("rst_busy", oBUSY, 0);
        checkOutput("rst_ready", oREADY, 0);
        checkOutput("rst_mux", oMUX_SEL, 0);
        checkOutput("rst_set", oOUT_SET, 0);
        checkOutput("rst_valid", oVALID, 0);
        checkOutput("rst_start", oFHT_START, 0);

        applyStimulus(0, 0, 0, 1);
        @(negedge iCLK);
        checkOutput("idle_ready", oREADY, 0);
        applyStimulus(0, 1, 1, 1);
        @(negedge iCLK);
        checkOutput("en_ready_same_cycle", oREADY, 0);

        // Frame 1: continuous load, long core run, result set B, free output.
        cfgDelay = 0; cfgLow = 20; cfgSel = 1'b1;
        for (int k = 0; k < N; k++) begin
            applyStimulus(1, 1, 1, 1);
            @(negedge iCLK);
            if (k == 0) begin
                checkOutput("load_ready", oREADY, 1);
                checkOutput("load_mux", oMUX_SEL, 1);
            end
            checkOutput("load_we", oIN_WE, 1);
            checkOutput("load_bank", oIN_BANK, k % 4);
            checkOutput("load_addr", oIN_ADDR, k / 4);
        end
        runUntilDone(300, 0, 0, 0, starts, accepts, latency, gotDone);
        checkOutput("f1_done", gotDone, 1);
        checkOutput("f1_starts", starts, 1);
        checkOutput("f1_accepts", accepts, 16);
        checkOutput("f1_set", oOUT_SET, 1);
        checkOutput("f1_latency", latency, 2);

        // Frame 2: back-to-back, 1-cycle RDY glitch, stalled output, iEN dropped.
        cfgDelay = 1; cfgLow = 1; cfgSel = 1'b0;
        applyStimulus(1, 1, 0, 1);
        @(negedge iCLK);
        checkOutput("b2b_ready", oREADY, 1);
        checkOutput("b2b_bank", oIN_BANK, 0);
        checkOutput("b2b_addr", oIN_ADDR, 0);
        runUntilDone(400, 0, 1, 1, starts, accepts, latency, gotDone);
        checkOutput("f2_done", gotDone, 1);
        checkOutput("f2_starts", starts, 1);
        checkOutput("f2_accepts", accepts, 16);
        checkOutput("f2_set", oOUT_SET, 0);
        applyStimulus(0, 1, 0, 1);
        @(negedge iCLK);
        checkOutput("f2_idle_busy", oBUSY, 0);
        checkOutput("f2_idle_mux", oMUX_SEL, 0);

        // Reset after eight loaded samples, then a clean restart.
        applyStimulus(0, 1, 1, 1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 1, 1, 1);
            @(negedge iCLK);
        end
        applyStimulus(1, 1, 1, 0);
        #1;
        checkOutput("mid_busy", oBUSY, 0);
        checkOutput("mid_ready", oREADY, 0);
        checkOutput("mid_we", oIN_WE, 0);
        checkOutput("mid_mux", oMUX_SEL, 0);
        checkOutput("mid_addr", oIN_ADDR, 0);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(1, 1, 1, 1);
        @(negedge iCLK);
        checkOutput("restart_we", oIN_WE, 1);
        checkOutput("restart_bank", oIN_BANK, 0);
        checkOutput("restart_addr", oIN_ADDR, 0);
        runUntilDone(400, 0, 0, 0, starts, accepts, latency, gotDone);
        checkOutput("restart_done", gotDone, 1);
        checkOutput("restart_accepts", accepts, 16);

        // Randomized frames with random handshakes, enables and rare resets.
        for (int f = 0; f < 8; f++) begin
            cfgDelay = $urandom_range(0, 2);
            cfgLow   = $urandom_range(1, 6);
            cfgSel   = 1'($urandom % 2);
            runUntilDone(1500, 1, 2, 2, starts, accepts, latency, gotDone);
            checkOutput("rand_done", gotDone, 1);
        end
        cfgIdleRdy = 1'b1;
        applyStimulus(0, 1, 0, 1);
        @(negedge iCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
